// File: rtl/round_robin_arbiter_16.sv
// 16-source round-robin arbiter driving a 16x20 mux select; ARB_LOCK_EN enables burst hold via lock.
// Latency: 1 cycle from req sample to out_valid; while out_ready=0 the grant is frozen and req is ignored.
module round_robin_arbiter_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        out_ready,
  input  logic        lock,
  output logic [3:0]  addr,
  output logic [15:0] grant,
  output logic        out_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ptr;
  logic [3:0]  ptr_nxt;
  logic [3:0]  addr_nxt;
  logic [3:0]  win_idx;
  logic [3:0]  scan_idx;
  logic        win_vld;
  logic        hold;

  // Scan starts at ptr; the 4-bit sum wraps 15->0.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr;
    scan_idx = ptr;
    for (int k = 0; k < 16; k++) begin
      scan_idx = ptr + 4'(k);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign hold = lock & req[addr];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    addr_nxt  = addr;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          addr_nxt  = win_idx;
        end
      end
      GRANT: begin
        if (out_ready && !hold) begin
          state_nxt = IDLE;
          ptr_nxt   = addr + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    grant     = '0;
    if (state == GRANT) begin
      out_valid = 1'b1;
      grant     = 16'd1 << addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 4'd0;
      addr  <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      addr  <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_16.sv
// Directed bench for round_robin_arbiter_16; outputs sampled 1ns after each rising edge.
module tb_round_robin_arbiter_16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  logic        lock;
  logic [3:0]  addr;
  logic [15:0] grant;
  logic        out_valid;

  int checks;
  int failures;

  round_robin_arbiter_16 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .lock      (lock),
    .addr      (addr),
    .grant     (grant),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b1; lock = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || addr !== 4'd0 || grant !== 16'h0000) begin
        failures++;
        $display("FAIL reset_%0d: valid=%b addr=%0d grant=%h, expected 0 0 0000", i, out_valid, addr, grant);
      end
    end
    rst = 1'b0; req = 16'h0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0000) begin
      failures++;
      $display("FAIL idle_no_req: valid=%b grant=%h, expected 0 0000", out_valid, grant);
    end
  endtask

  task automatic test_single();
    req = 16'h0001; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd0 || grant !== 16'h0001) begin
      failures++;
      $display("FAIL single_grant: valid=%b addr=%0d grant=%h, expected 1 0 0001", out_valid, addr, grant);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0000 || addr !== 4'd0) begin
      failures++;
      $display("FAIL single_bubble: valid=%b addr=%0d grant=%h, expected 0 0 0000", out_valid, addr, grant);
    end
    req = 16'h0000;
  endtask

  task automatic test_rotation();
    logic [3:0]  exp_a;
    logic [15:0] exp_g;
    do_reset();
    req = 16'hFFFF; out_ready = 1'b1; lock = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      exp_a = 4'(i);
      exp_g = 16'd1 << exp_a;
      tick();
      checks++;
      if (out_valid !== 1'b1 || addr !== exp_a || grant !== exp_g) begin
        failures++;
        $display("FAIL rotate_grant_%0d: valid=%b addr=%0d grant=%h, expected 1 %0d %h", i, out_valid, addr, grant, exp_a, exp_g);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || addr !== exp_a || grant !== 16'h0000) begin
        failures++;
        $display("FAIL rotate_bubble_%0d: valid=%b addr=%0d grant=%h, expected 0 %0d 0000", i, out_valid, addr, grant, exp_a);
      end
    end
    req = 16'h0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd14 || grant !== 16'h4000) begin
      failures++;
      $display("FAIL wrap_pre14: valid=%b addr=%0d grant=%h, expected 1 14 4000", out_valid, addr, grant);
    end
    tick();
    req = 16'h8008;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd15 || grant !== 16'h8000) begin
      failures++;
      $display("FAIL wrap_15: valid=%b addr=%0d grant=%h, expected 1 15 8000", out_valid, addr, grant);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd3 || grant !== 16'h0008) begin
      failures++;
      $display("FAIL wrap_3: valid=%b addr=%0d grant=%h, expected 1 3 0008", out_valid, addr, grant);
    end
    tick();
    req = 16'h0000;
  endtask

  task automatic test_backpressure();
    logic [15:0] toggles [5] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h8000};
    do_reset();
    req = 16'h0040; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd6 || grant !== 16'h0040) begin
      failures++;
      $display("FAIL bp_grant6: valid=%b addr=%0d grant=%h, expected 1 6 0040", out_valid, addr, grant);
    end
    for (int i = 0; i < 5; i++) begin
      req = toggles[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || addr !== 4'd6 || grant !== 16'h0040) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b addr=%0d grant=%h, expected 1 6 0040", i, out_valid, addr, grant);
      end
    end
    out_ready = 1'b1; req = 16'h0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0000) begin
      failures++;
      $display("FAIL bp_release: valid=%b grant=%h, expected 0 0000", out_valid, grant);
    end
    req = 16'hFFFF;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd7 || grant !== 16'h0080) begin
      failures++;
      $display("FAIL bp_next_ptr: valid=%b addr=%0d grant=%h, expected 1 7 0080", out_valid, addr, grant);
    end
    tick();
    req = 16'h0000;
  endtask

  task automatic test_lock();
    logic exp_v [3];
`ifdef ARB_LOCK_EN
    exp_v = '{1'b1, 1'b1, 1'b1};
`else
    exp_v = '{1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    req = 16'h0020; lock = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== exp_v[i] || addr !== 4'd5 || grant !== (exp_v[i] ? 16'h0020 : 16'h0000)) begin
        failures++;
        $display("FAIL lock_%0d: valid=%b addr=%0d grant=%h, expected valid %b addr 5", i, out_valid, addr, grant, exp_v[i]);
      end
    end
    lock = 1'b0; req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    req = 16'h0010; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || addr !== 4'd4) begin
      failures++;
      $display("FAIL rig_grant4: valid=%b addr=%0d, expected 1 4", out_valid, addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || addr !== 4'd0 || grant !== 16'h0000) begin
      failures++;
      $display("FAIL rig_reset: valid=%b addr=%0d grant=%h, expected 0 0 0000", out_valid, addr, grant);
    end
    rst = 1'b0; req = 16'h0000; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant !== 16'h0000) begin
      failures++;
      $display("FAIL rig_no_pulse: valid=%b grant=%h, expected 0 0000", out_valid, grant);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req = 16'h0000; out_ready = 1'b0; lock = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_backpressure();
    test_lock();
    test_reset_in_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_16.md
ROUND_ROBIN_ARBITER_16 -- requirements
Module: round_robin_arbiter_16

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising clk edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  16  per-source request; bit i means source i holds a 20-bit word on the 16:1 mux input i.
REQ-005 out_ready  input  1  downstream accepts the current mux output this cycle.
REQ-006 lock  input  1  burst hold request from the granted source; used only when ARB_LOCK_EN is defined.
REQ-007 addr  output  4  select for the 16x20-bit mux; equals the granted source index.
REQ-008 grant  output  16  one-hot grant; bit addr set while out_valid=1, else all zero.
REQ-009 out_valid  output  1  mux output is valid for the granted source.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE: out_valid=0 and grant=0; addr holds its last value.
REQ-012 IDLE with req!=0: the winner SHALL be the first set req bit at or above ptr, searching ascending and wrapping 15->0; next cycle the FSM is GRANT, addr=winner, grant=1<<winner, out_valid=1.
REQ-013 IDLE with req=0: stay IDLE; ptr unchanged.
REQ-014 Arbitration latency SHALL be exactly one cycle from the req sample to out_valid=1.
REQ-015 GRANT with out_ready=0: addr, grant and out_valid SHALL stay constant; req changes, including deassertion of the granted bit, SHALL be ignored.
REQ-016 GRANT with out_ready=1 (transfer): ptr SHALL become (winner+1) mod 16, and the next state SHALL be IDLE, except as in REQ-022.
REQ-017 With continuous requests, throughput SHALL be one transfer per two cycles: one IDLE bubble after each transfer.
REQ-018 The ptr register SHALL be 4 bits and wrap modulo 16.
REQ-019 grant SHALL never have more than one bit set.

Reset
REQ-020 When rst=1 at a clock edge, the next state SHALL be: state=IDLE, ptr=0, addr=0, grant=0, out_valid=0, regardless of the current state or inputs.
REQ-021 A reset asserted in GRANT SHALL discard the pending transfer; there SHALL be no out_valid pulse in the cycle after reset.

Configuration
REQ-022 Macro ARB_LOCK_EN defined: in GRANT with out_ready=1, lock=1 and req[addr]=1, the FSM SHALL stay in GRANT with the same addr; ptr SHALL NOT advance, giving back-to-back transfers.
REQ-023 Macro ARB_LOCK_EN undefined: the lock input SHALL be ignored and REQ-016 SHALL always apply.

Verification
REQ-024 Reset: rst=1 for 2 cycles with req=0xFFFF -> addr=0, grant=0, out_valid=0 in the cycle after each reset edge.
REQ-025 Single source: req=0x0001, out_ready=1 -> next cycle grant=0x0001, addr=0, out_valid=1; the following cycle out_valid=0.
REQ-026 Rotation: req=0xFFFF, out_ready=1 always -> addr sequence 0,1,2,...,15,0, one grant every 2 cycles.
REQ-027 Wrap: ptr=15 (after a grant to source 14), req=0x8008 -> grant to 15, then to 3.
REQ-028 Backpressure: in GRANT to source 6, hold out_ready=0 for 5 cycles and toggle req -> addr=6 and grant=0x0040 stable; the transfer completes on the first cycle with out_ready=1.
REQ-029 Lock: with ARB_LOCK_EN defined, req=0x0020, lock=1, out_ready=1 for 3 cycles -> out_valid=1 and addr=5 in all 3 cycles. Without the macro, out_valid toggles 1,0,1.
